data_ram_sync: RTL
==================

Name: data_ram_sync

Overview:
- Clocked, parametrised successor to the combinational byte-addressed data RAM.
- Serves the MEM stage of the pipelined ARM datapath with byte, half-word and word loads/stores in big-endian byte order.
- Adds a req/done handshake, programmable wait-state latency, sign/zero extension of sub-word loads, and error reporting for misaligned, out-of-range or illegal-size accesses.
- Sits between the EX/MEM pipeline register and the MEM/WB register; the pipeline stalls on busy.

Parameters:
- DEPTH, 256, memory size in bytes; power of two, at least 4.
- ADDR_W, 32, width of the address port.
- LATENCY, 1, wait cycles inserted before an access completes; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  1  access request; sampled only while in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 half-word, 10 word, 11 illegal.
- sign_ext  in  1  for loads, sign-extend sub-word data; 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; the low bytes are used for byte and half-word stores.
- rdata  out  32  load result; holds its value until the next successful load completes.
- done  out  1  one-cycle pulse marking completion of the accepted access.
- err  out  1  valid with done; 1 = access rejected.
- busy  out  1  high from the cycle after acceptance until done is asserted.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the block enters IDLE and rdata=0, done=0, err=0, busy=0, wait counter=0.
  - Memory contents are not cleared; the bench preloads them through a hierarchical $readmemh.
  - Reset mid-operation abandons the pending access. A pending store is not performed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge with req=1, latch we, size, sign_ext, addr and wdata. Set busy=1 and the counter to LATENCY.
    - If LATENCY=0, go to RESP; otherwise go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
  - RESP: perform the access using the latched values. Assert done for this cycle only, clear busy, and return to IDLE.
- Timing: req sampled at edge N gives done high during cycle N+LATENCY+1.
  - req arriving during the RESP cycle is not sampled; it must be held and is taken from IDLE on the next edge.
  - req, and changes to any input, are ignored while busy=1, because all inputs are latched at acceptance.
- Error checks, evaluated on the latched values:
  - size=11;
  - half-word with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr+bytes-1 >= DEPTH.
  - On error: err=1 with done, no memory write, rdata unchanged. The access still takes the full latency.
- Byte order (big-endian):
  - Word: Mem[a] goes to bits [31:24], through Mem[a+3] to bits [7:0].
  - Half-word: Mem[a] goes to [15:8], Mem[a+1] to [7:0].
  - Stores write wdata[31:0], wdata[15:0] or wdata[7:0] correspondingly.
- Load extension: byte and half-word results fill the upper bits with the MSB of the loaded data when sign_ext=1, and with 0 otherwise. sign_ext is ignored for words and for stores.
- Stores leave rdata unchanged.
- Write-then-read to the same address in consecutive transactions returns the new data.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state typedef {IDLE, WAIT, RESP};
  - a function bytes_of(size).
- One natural sub-module: load_align. It is combinational: from the four bytes read, size and sign_ext, it produces the extended 32-bit rdata value. The FSM and storage stay in the top module.

Test Plan:
- LATENCY=1, store word 0xDEADBEEF at 0x10 with req at edge 0 -> busy in cycle 1, done in cycle 2 with err=0; Mem[0x10..0x13] = DE,AD,BE,EF. A following word load at 0x10 returns rdata=0xDEADBEEF.
- Byte load at 0x11 -> sign_ext=1 gives rdata=0xFFFFFFAD; sign_ext=0 gives 0x000000AD. Half-word load at 0x12 with sign_ext=1 gives 0xFFFFBEEF.
- Word load at 0x12 (misaligned), size=11, and word load at DEPTH-2 -> each returns done=1, err=1, rdata unchanged. A store at DEPTH-2 leaves memory unmodified.
- LATENCY=0 and LATENCY=3 builds -> done occurs exactly 1 and 4 cycles after acceptance. A req toggled and addr changed while busy have no effect.
- rst_n=0 asserted in a WAIT cycle of a word store to 0x20 -> the next edge gives IDLE and busy=0; no done pulse; Mem[0x20..0x23] unchanged.
- Back-to-back: req held high continuously -> accepted in the cycle after each done. Store then load to the same address returns the stored value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the synchronous data RAM.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Number of bytes touched by an access; 0 flags the illegal encoding.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/load_align.sv
// Turns four big-endian bytes read at the access address into the 32-bit
// load result, sign- or zero-extending byte and half-word loads.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);
  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{sign_ext & raw[31]}}, raw[31:24]};
      SZ_HALF: data = {{16{sign_ext & raw[31]}}, raw[31:16]};
      default: data = raw;
    endcase
  end
endmodule

// File: rtl/data_ram_sync.sv
// Clocked big-endian byte-addressed data RAM for the MEM stage.
// req/done handshake with LATENCY wait states; errors are reported with done.
module data_ram_sync
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy
);
  localparam int              AW    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              we_q, sign_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     idx [4];
  logic [ADDR_W:0]   last;
  logic              bad;
  logic [31:0]       raw, ld_data;

  // Extra top bit keeps addr+bytes-1 from wrapping at the top of the space.
  always_comb begin
    last = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, bytes_of(size_q)} - ONE;
    bad  = (size_q == 2'b11)
        || (size_q == SZ_HALF && addr_q[0])
        || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
        || (last >= LIMIT);
    for (int k = 0; k < 4; k++) idx[k] = addr_q[AW-1:0] + AW'(k);
    raw = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
  end

  load_align u_align (
    .raw      (raw),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (ld_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done  = (state == RESP);
  assign err   = done & bad;
  assign busy  = (state == WAIT);
  assign rdata = (done && !we_q && !bad) ? ld_data : rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        sign_q  <= sign_ext;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (done && !we_q && !bad) rdata_q <= ld_data;
    end
  end

  // Storage is never cleared; a reset landing on RESP drops the store.
  always_ff @(posedge clk) begin
    if (rst_n && done && we_q && !bad) begin
      case (size_q)
        SZ_BYTE: mem[idx[0]] <= wdata_q[7:0];
        SZ_HALF: begin
          mem[idx[0]] <= wdata_q[15:8];
          mem[idx[1]] <= wdata_q[7:0];
        end
        default: begin
          mem[idx[0]] <= wdata_q[31:24];
          mem[idx[1]] <= wdata_q[23:16];
          mem[idx[2]] <= wdata_q[15:8];
          mem[idx[3]] <= wdata_q[7:0];
        end
      endcase
    end
  end
endmodule
